// File: rtl/sha3_pkg.sv
// Shared SHA-3 constants, rate table and absorb-side FSM state type.
package sha3_pkg;

  localparam int unsigned LANE_W     = 64;
  localparam int unsigned LANE_BYTES = 8;
  localparam int unsigned STATE_W    = 1600;

  localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
  localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_END      = 8'h80;

  // Rate in 64-bit lanes for each standard variant.
  localparam int unsigned RATE_SHA3_224 = 18;
  localparam int unsigned RATE_SHA3_256 = 17;
  localparam int unsigned RATE_SHA3_384 = 13;
  localparam int unsigned RATE_SHA3_512 = 9;
  localparam int unsigned RATE_SHAKE128 = 21;
  localparam int unsigned RATE_SHAKE256 = 17;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    OUT
  } state_t;

  // Byte counts above a full lane saturate to a full lane.
  function automatic logic [3:0] clamp_bytes(input logic [3:0] n);
    return (n > 4'd8) ? 4'd8 : n;
  endfunction

endpackage

// File: rtl/sha3_lane_mask.sv
// Byte-keep mask for a 64-bit lane: bytes below nbytes kept, the rest zeroed.
module sha3_lane_mask
  import sha3_pkg::*;
(
  input  logic [3:0]        nbytes,
  output logic [LANE_W-1:0] mask
);

  always_comb begin
    mask = '0;
    for (int unsigned k = 0; k < LANE_BYTES; k++) begin
      if (4'(k) < nbytes) mask[8*k +: 8] = '1;
    end
  end

endmodule

// File: rtl/sha3_absorb_pad.sv
// Assembles 64-bit message lanes into rate blocks, applies SHA-3 multi-rate
// padding, and hands each block to the permutation core.
module sha3_absorb_pad
  import sha3_pkg::*;
#(
  parameter int unsigned RATE_WORDS = 17,
  parameter logic [7:0]  DOMAIN     = DOMAIN_SHA3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [LANE_W-1:0]            IN_DATA,
  input  logic [3:0]                   IN_BYTES,
  input  logic                         IN_LAST,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  output logic [LANE_W*RATE_WORDS-1:0] BLOCK_OUT,
  output logic                         BLOCK_LAST,
  output logic                         BLOCK_VALID,
  input  logic                         BLOCK_READY
);

  localparam int unsigned     IDX_W    = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_WORDS - 1);

  state_t                               state;
  logic [IDX_W-1:0]                     idx;
  logic [IDX_W-1:0]                     pad_word;
  logic [2:0]                           pad_byte;
  logic                                 pad_pending;
  logic [RATE_WORDS-1:0][LANE_W-1:0]    buffer;
  logic [RATE_WORDS-1:0][LANE_W-1:0]    padded;
  logic [LANE_W-1:0]                    keep;
  logic [LANE_W-1:0]                    lane;
  logic [3:0]                           nbytes;
  logic                                 accept;

  sha3_lane_mask u_mask (
    .nbytes (IN_BYTES),
    .mask   (keep)
  );

  assign nbytes    = clamp_bytes(IN_BYTES);
  assign lane      = IN_LAST ? (IN_DATA & keep) : IN_DATA;
  assign IN_READY  = (state == FILL) && !RST;
  assign accept    = IN_VALID && IN_READY;
  assign BLOCK_OUT = buffer;

  // Both pad bytes are applied as XORs so they combine to 0x86 when they coincide.
  always_comb begin
    padded = buffer;
    for (int unsigned w = 0; w < RATE_WORDS; w++) begin
      if (IDX_W'(w) == pad_word)
        padded[w][{pad_byte, 3'b000} +: 8] = buffer[w][{pad_byte, 3'b000} +: 8] ^ DOMAIN;
    end
    padded[RATE_WORDS-1][LANE_W-1 -: 8] = padded[RATE_WORDS-1][LANE_W-1 -: 8] ^ PAD_END;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= FILL;
      idx         <= '0;
      buffer      <= '0;
      pad_pending <= 1'b0;
      pad_word    <= '0;
      pad_byte    <= '0;
      BLOCK_VALID <= 1'b0;
      BLOCK_LAST  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            for (int unsigned w = 0; w < RATE_WORDS; w++) begin
              if (IDX_W'(w) == idx) buffer[w] <= lane;
            end
            if (!IN_LAST) begin
              if (idx == LAST_IDX) begin
                idx         <= '0;
                BLOCK_LAST  <= 1'b0;
                BLOCK_VALID <= 1'b1;
                state       <= OUT;
              end else begin
                idx <= idx + 1'b1;
              end
            end else if (nbytes != 4'd8) begin
              pad_word <= idx;
              pad_byte <= nbytes[2:0];
              state    <= PAD;
            end else if (idx != LAST_IDX) begin
              pad_word <= idx + 1'b1;
              pad_byte <= '0;
              state    <= PAD;
            end else begin
              // Full last lane fills the block: padding goes into a fresh block.
              pad_word    <= '0;
              pad_byte    <= '0;
              pad_pending <= 1'b1;
              BLOCK_LAST  <= 1'b0;
              BLOCK_VALID <= 1'b1;
              state       <= OUT;
            end
          end
        end
        PAD: begin
          buffer      <= padded;
          BLOCK_LAST  <= 1'b1;
          pad_pending <= 1'b0;
          BLOCK_VALID <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (BLOCK_READY) begin
            buffer      <= '0;
            idx         <= '0;
            BLOCK_VALID <= 1'b0;
            state       <= pad_pending ? PAD : FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_absorb_pad.sv
// Scoreboard bench for sha3_absorb_pad: byte-level padding model vs. DUT blocks.
module tb_sha3_absorb_pad;

  localparam int RW = 17;
  localparam int RB = RW * 8;
  localparam int BW = 64 * RW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   in_data = '0;
  logic [3:0]    in_bytes = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] block_out;
  logic          block_last;
  logic          block_valid;
  logic          block_ready = 1'b0;

  always #5 clk = ~clk;

  sha3_absorb_pad #(
    .RATE_WORDS (RW),
    .DOMAIN     (8'h06)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .IN_DATA     (in_data),
    .IN_BYTES    (in_bytes),
    .IN_LAST     (in_last),
    .IN_VALID    (in_valid),
    .IN_READY    (in_ready),
    .BLOCK_OUT   (block_out),
    .BLOCK_LAST  (block_last),
    .BLOCK_VALID (block_valid),
    .BLOCK_READY (block_ready)
  );

  typedef struct {
    logic [BW-1:0] blk;
    bit            last;
    int            lat;
  } exp_t;

  exp_t         q[$];
  byte unsigned msg[0:1023];
  int           checks = 0;
  int           errors = 0;
  int           rdy_mode = 1;
  bit           gap_en = 0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: pad the whole message as a byte string, then cut into rate blocks.
  task automatic push_expected(input int len);
    int nb;
    byte unsigned p[];
    exp_t e;
    nb = len / RB + 1;
    p = new[nb * RB];
    for (int i = 0; i < nb * RB; i++) p[i] = (i < len) ? msg[i] : 8'h00;
    p[len] ^= 8'h06;
    p[nb * RB - 1] ^= 8'h80;
    for (int b = 0; b < nb; b++) begin
      e.blk = '0;
      for (int j = 0; j < RB; j++) e.blk[8*j +: 8] = p[b * RB + j];
      e.last = (b == nb - 1);
      if (b < nb - 1) e.lat = 1;
      else e.lat = (len % RB == 0 && len > 0) ? 0 : 2;
      q.push_back(e);
    end
  endtask

  task automatic send_lane(input logic [63:0] d, input logic [3:0] nb, input logic last);
    int n;
    in_data  = d;
    in_bytes = nb;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(n < 5000, "in_ready_wait", 64'(n), 64'd5000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_msg(input int len, input bit over8);
    int nl;
    int nb;
    logic [63:0] d;
    nl = (len == 0) ? 1 : (len + 7) / 8;
    push_expected(len);
    for (int i = 0; i < nl; i++) begin
      for (int k = 0; k < 8; k++) d[8*k +: 8] = msg[8*i + k];
      nb = (i == nl - 1) ? len - 8 * i : 8;
      if (i == nl - 1 && nb == 8 && over8) nb = 8 + $urandom_range(0, 7);
      send_lane(d, 4'(nb), i == nl - 1);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(q.size() == 0, "drain", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_msg();
    for (int i = 0; i < 1024; i++) msg[i] = 8'($urandom);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       block_ready = 1'b0;
        1:       block_ready = 1'b1;
        default: block_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks hold/latency rules.
  int            cyc = 0;
  int            acc_cyc = 0;
  int            blkno = 0;
  bit            prev_valid = 0;
  bit            prev_ready = 0;
  logic [BW-1:0] held_out;
  logic          held_last;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      prev_valid = 0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (block_valid) begin
        check(in_ready == 1'b0, "in_ready_during_out", 64'(in_ready), 64'd0);
        if (prev_valid && !prev_ready) begin
          check(block_out == held_out, "block_out_stable", 64'(block_out == held_out), 64'd1);
          check(block_last == held_last, "block_last_stable", 64'(block_last), 64'(held_last));
        end
        if (!prev_valid && q.size() > 0 && q[0].lat != 0)
          check(cyc - acc_cyc == q[0].lat, "valid_latency", 64'(cyc - acc_cyc), 64'(q[0].lat));
        if (block_ready) begin
          if (q.size() == 0) begin
            check(1'b0, "unexpected_block", 64'(blkno), 64'd0);
          end else begin
            e = q.pop_front();
            for (int w = 0; w < RW; w++)
              check(block_out[64*w +: 64] == e.blk[64*w +: 64],
                    $sformatf("blk%0d_word%0d", blkno, w),
                    block_out[64*w +: 64], e.blk[64*w +: 64]);
            check(block_last == e.last, $sformatf("blk%0d_last", blkno),
                  64'(block_last), 64'(e.last));
          end
          blkno++;
        end
        held_out  = block_out;
        held_last = block_last;
      end
      prev_valid = block_valid;
      prev_ready = block_ready;
    end
  end

  initial begin
    int n;
    int len;
    int corner[8];
    corner = '{0, 7, 8, 135, 136, 137, 271, 272};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(in_ready == 1'b0, "in_ready_in_reset", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check(block_valid == 1'b0, "reset_block_valid", 64'(block_valid), 64'd0);
    check(block_last == 1'b0, "reset_block_last", 64'(block_last), 64'd0);
    check(in_ready == 1'b1, "reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Empty message.
    rdy_mode = 1;
    send_msg(0, 0);
    wait_drain();

    // "abc" with garbage in the unused bytes.
    for (int i = 0; i < 8; i++) msg[i] = 8'hFF;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3, 0);
    wait_drain();

    // Pad bytes coinciding in the last rate byte, then the full-block case.
    rand_msg();
    send_msg(135, 0);
    wait_drain();
    rand_msg();
    send_msg(136, 0);
    wait_drain();

    // Backpressure: hold off the core for 10 cycles while a lane waits.
    rdy_mode = 0;
    rand_msg();
    fork
      send_msg(200, 0);
      begin
        n = 0;
        while (!block_valid && n < 500) begin
          @(negedge clk);
          n++;
        end
        check(n < 500, "bp_valid_wait", 64'(n), 64'd500);
        repeat (10) @(posedge clk);
        #1;
        rdy_mode = 1;
      end
    join
    wait_drain();

    // Reset in the middle of a message must leave no residue.
    rand_msg();
    for (int i = 0; i < 5; i++) send_lane({$urandom, $urandom}, 4'd8, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check(in_ready == 1'b0, "in_ready_mid_reset", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) msg[i] = 8'hFF;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3, 0);
    wait_drain();

    // Randomized messages with random gaps and random core backpressure.
    gap_en   = 1;
    rdy_mode = 2;
    for (int t = 0; t < 25; t++) begin
      rand_msg();
      if ($urandom_range(0, 2) == 0) len = corner[$urandom_range(0, 7)];
      else len = $urandom_range(0, 420);
      send_msg(len, 1);
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=%0d expected=0", q.size());
    $fatal(1, "timeout");
  end

endmodule
